mem_stage_unit: RTL and testbench

//  MEM pipeline stage, directly downstream of the EX/MEM register. Holds the data RAM.

---
 rtl/mem_stage_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// mem_stage_unit
//   MEM pipeline stage sitting directly after the EX/MEM register. Owns a byte-addressed
//   little-endian data RAM, performs byte/halfword/word loads and stores with an optional
//   number of wait states, stalls upstream while an access is pending and registers the
//   results into the MEM/WB outputs that feed the writeback mux.
//
// Parameters
//   ADDR_BITS        byte-address width; the RAM holds 2**ADDR_BITS bytes (must be >= 3)
//   WAIT_CYCLES      extra cycles per memory access (0 = single-cycle access)
//
// Ports
//   CLK              clock, all state updates on the rising edge
//   CLR              synchronous active-high reset (RAM contents are kept)
//   Size_In          00 byte, 01 halfword, 10/11 word
//   Enable_In        memory access request this cycle
//   rw_In            1 = store, 0 = load
//   Load_In          writeback selects memory data (passed through)
//   rf_In            register-file write enable (passed through)
//   RegFile_PortC_In store data
//   ALU_In           effective byte address / ALU result
//   Rd_In            destination register
//   Stall_Out        combinational; upstream holds all inputs while high
//   Misalign_Out     registered; captured access had nonzero dropped address bits
//   Load_Out         MEM/WB load select
//   rf_Out           MEM/WB register-file write enable
//   Mem_Data_Out     MEM/WB load data, zero-extended
//   ALU_Out          MEM/WB ALU result
//   Rd_Out           MEM/WB destination register

module mem_stage_unit #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [1:0]  Size_In,
    input  logic        Enable_In,
    input  logic        rw_In,
    input  logic        Load_In,
    input  logic        rf_In,
    input  logic [31:0] RegFile_PortC_In,
    input  logic [31:0] ALU_In,
    input  logic [3:0]  Rd_In,
    output logic        Stall_Out,
    output logic        Misalign_Out,
    output logic        Load_Out,
    output logic        rf_Out,
    output logic [31:0] Mem_Data_Out,
    output logic [31:0] ALU_Out,
    output logic [3:0]  Rd_Out
);

    localparam int unsigned Depth = 1 << ADDR_BITS;
    // The counter only ever holds WAIT_CYCLES-1 down to 0.
    localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    logic [7:0] mem [Depth];

    // Address alignment and byte-lane addresses.
    logic [ADDR_BITS-1:0] addr_raw;
    logic [ADDR_BITS-1:0] addr_b0;
    logic [ADDR_BITS-1:0] addr_b1;
    logic [ADDR_BITS-1:0] addr_b2;
    logic [ADDR_BITS-1:0] addr_b3;
    logic                 misalign;
    logic [31:0]          rd_word;
    logic [31:0]          load_data;
    logic                 access_done;
    logic                 mem_we;

    always_comb begin
        addr_raw = ALU_In[ADDR_BITS-1:0];
        addr_b0  = addr_raw;
        misalign = 1'b0;
        case (Size_In)
            2'b00: begin
                addr_b0  = addr_raw;
                misalign = 1'b0;
            end
            2'b01: begin
                addr_b0  = {addr_raw[ADDR_BITS-1:1], 1'b0};
                misalign = addr_raw[0];
            end
            default: begin
                addr_b0  = {addr_raw[ADDR_BITS-1:2], 2'b00};
                misalign = |addr_raw[1:0];
            end
        endcase
        // Lane addresses wrap modulo the RAM size.
        addr_b1 = addr_b0 + ADDR_BITS'(1);
        addr_b2 = addr_b0 + ADDR_BITS'(2);
        addr_b3 = addr_b0 + ADDR_BITS'(3);
    end

    always_comb begin
        rd_word = {mem[addr_b3], mem[addr_b2], mem[addr_b1], mem[addr_b0]};
        case (Size_In)
            2'b00:   load_data = {24'h0, rd_word[7:0]};
            2'b01:   load_data = {16'h0, rd_word[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // Stall covers the whole request phase; the final cycle of an access never stalls.
    always_comb begin
        if (state_q == StIdle) begin
            Stall_Out = Enable_In && (WAIT_CYCLES != 0);
        end else begin
            Stall_Out = (cnt_q != '0);
        end
    end

    // The access completes on the edge where Stall_Out is low with a request present.
    assign access_done = Enable_In && !Stall_Out;
    // Reset wins over a completing store so an aborted access never reaches the RAM.
    assign mem_we      = access_done && rw_In && !CLR;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr_b0] <= RegFile_PortC_In[7:0];
            if (Size_In != 2'b00) begin
                mem[addr_b1] <= RegFile_PortC_In[15:8];
            end
            if (Size_In[1]) begin
                mem[addr_b2] <= RegFile_PortC_In[23:16];
                mem[addr_b3] <= RegFile_PortC_In[31:24];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            Misalign_Out <= 1'b0;
            Load_Out     <= 1'b0;
            rf_Out       <= 1'b0;
            Mem_Data_Out <= 32'h0;
            ALU_Out      <= 32'h0;
            Rd_Out       <= 4'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Enable_In && (WAIT_CYCLES != 0)) begin
                        state_q <= StBusy;
                        cnt_q   <= CntW'(WAIT_CYCLES - 1);
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase

            if (Stall_Out) begin
                // Bubble into MEM/WB while the access is pending.
                Misalign_Out <= 1'b0;
                Load_Out     <= 1'b0;
                rf_Out       <= 1'b0;
                Mem_Data_Out <= 32'h0;
                ALU_Out      <= 32'h0;
                Rd_Out       <= 4'h0;
            end else begin
                Misalign_Out <= Enable_In && misalign;
                Load_Out     <= Load_In;
                rf_Out       <= rf_In;
                // Read data is sampled before a same-edge store lands.
                Mem_Data_Out <= Enable_In ? load_data : 32'h0;
                ALU_Out      <= ALU_In;
                Rd_Out       <= Rd_In;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit
//   Three instances (WAIT_CYCLES 0, 2 and 3) driven independently and compared against a
//   byte-array reference model of the data RAM and the stage timing.

module tb_mem_stage_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr   [3];
    logic [1:0]  size  [3];
    logic        en    [3];
    logic        rw    [3];
    logic        ld    [3];
    logic        rf    [3];
    logic [31:0] wd    [3];
    logic [31:0] alu   [3];
    logic [3:0]  rd    [3];
    logic        stall [3];
    logic        mis   [3];
    logic        ld_o  [3];
    logic        rf_o  [3];
    logic [31:0] md_o  [3];
    logic [31:0] alu_o [3];
    logic [3:0]  rd_o  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_unit #(
            .ADDR_BITS  (8),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .CLK             (clk),
            .CLR             (clr[g]),
            .Size_In         (size[g]),
            .Enable_In       (en[g]),
            .rw_In           (rw[g]),
            .Load_In         (ld[g]),
            .rf_In           (rf[g]),
            .RegFile_PortC_In(wd[g]),
            .ALU_In          (alu[g]),
            .Rd_In           (rd[g]),
            .Stall_Out       (stall[g]),
            .Misalign_Out    (mis[g]),
            .Load_Out        (ld_o[g]),
            .rf_Out          (rf_o[g]),
            .Mem_Data_Out    (md_o[g]),
            .ALU_Out         (alu_o[g]),
            .Rd_Out          (rd_o[g])
        );
    end

    logic [7:0] ref_mem [3][256];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_md"},  md_o[d], 32'h0);
        check({tag, "_alu"}, alu_o[d], 32'h0);
        check({tag, "_rd"},  32'(rd_o[d]), 32'h0);
        check({tag, "_ld"},  32'(ld_o[d]), 32'h0);
        check({tag, "_rf"},  32'(rf_o[d]), 32'h0);
        check({tag, "_mis"}, 32'(mis[d]), 32'h0);
    endtask

    // Called and returns at a falling edge.
    task automatic access(input int d, input logic [1:0] sz, input logic st,
                          input logic [31:0] a, input logic [31:0] data, input logic l,
                          input logic r, input logic [3:0] dst, input string tag,
                          output logic [31:0] got);
        int          nb;
        int          ad;
        int          base;
        int          w;
        logic        mis_e;
        logic [31:0] exp_rd;
        logic [31:0] tmp;
        w      = wait_of(d);
        nb     = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        ad     = int'(a % 256);
        base   = ad - (ad % nb);
        mis_e  = (ad % nb) != 0;
        exp_rd = 32'h0;
        for (int i = 0; i < nb; i++) begin
            exp_rd = exp_rd | (32'(ref_mem[d][(base + i) % 256]) << (8 * i));
        end
        size[d] = sz;
        en[d]   = 1'b1;
        rw[d]   = st;
        wd[d]   = data;
        alu[d]  = a;
        ld[d]   = l;
        rf[d]   = r;
        rd[d]   = dst;
        for (int k = 0; k < w; k++) begin
            #1;
            check({tag, "_stall_hi"}, 32'(stall[d]), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bub_rf"},  32'(rf_o[d]), 32'h0);
            check({tag, "_bub_md"},  md_o[d], 32'h0);
            check({tag, "_bub_alu"}, alu_o[d], 32'h0);
        end
        #1;
        check({tag, "_stall_lo"}, 32'(stall[d]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        en[d] = 1'b0;
        check({tag, "_ld"},  32'(ld_o[d]), 32'(l));
        check({tag, "_rf"},  32'(rf_o[d]), 32'(r));
        check({tag, "_alu"}, alu_o[d], a);
        check({tag, "_rd"},  32'(rd_o[d]), 32'(dst));
        check({tag, "_mis"}, 32'(mis[d]), 32'(mis_e));
        if (!st) begin
            check({tag, "_data"}, md_o[d], exp_rd);
        end
        got = md_o[d];
        if (st) begin
            for (int i = 0; i < nb; i++) begin
                tmp = data >> (8 * i);
                ref_mem[d][(base + i) % 256] = tmp[7:0];
            end
        end
    endtask

    task automatic idle(input int d, input logic [31:0] a, input logic [3:0] dst,
                        input logic l, input logic r, input string tag);
        en[d]   = 1'b0;
        alu[d]  = a;
        rd[d]   = dst;
        ld[d]   = l;
        rf[d]   = r;
        rw[d]   = 1'($urandom);
        size[d] = 2'($urandom);
        wd[d]   = $urandom;
        #1;
        check({tag, "_stall"}, 32'(stall[d]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_alu"}, alu_o[d], a);
        check({tag, "_rd"},  32'(rd_o[d]), 32'(dst));
        check({tag, "_ld"},  32'(ld_o[d]), 32'(l));
        check({tag, "_rf"},  32'(rf_o[d]), 32'(r));
        check({tag, "_md"},  md_o[d], 32'h0);
        check({tag, "_mis"}, 32'(mis[d]), 32'h0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] old;
        int          d;

        for (int i = 0; i < 3; i++) begin
            clr[i] = 1'b1; size[i] = 2'b00; en[i] = 1'b0; rw[i] = 1'b0; ld[i] = 1'b0;
            rf[i] = 1'b0; wd[i] = 32'h0; alu[i] = 32'h0; rd[i] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            alu[i] = 32'h1234_5678;
            rd[i]  = 4'h9;
            ld[i]  = 1'b1;
            rf[i]  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_zero(i, "reset");
            check("reset_stall", 32'(stall[i]), 32'd0);
            clr[i] = 1'b0;
        end

        // Fill every RAM with known data.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 64; j++) begin
                access(i, 2'b10, 1'b1, 32'(j * 4), $urandom, 1'b0, 1'b0, 4'(j), "prime", got);
            end
        end

        // Single-cycle word store/load and sub-word accesses.
        access(0, 2'b10, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4'h1, "t1_st", got);
        access(0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 4'h2, "t1_ld", got);
        check("t1_word", got, 32'hDEADBEEF);
        access(0, 2'b00, 1'b1, 32'h11, 32'h123456AA, 1'b0, 1'b0, 4'h3, "t2_stb", got);
        access(0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 4'h4, "t2_ldw", got);
        check("t2_word", got, 32'hDEADAAEF);
        access(0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 4'h5, "t2_ldb", got);
        check("t2_byte", got, 32'h000000DE);
        access(0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 4'h6, "t2_ldh", got);
        check("t2_half", got, 32'h0000DEAD);

        // Wait-state access: two stall cycles with bubbles.
        access(1, 2'b10, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 4'h7, "t3_st", got);
        access(1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 4'h8, "t3_ld", got);
        check("t3_word", got, 32'hCAFEF00D);

        // Misaligned accesses align down and flag, aligned access clears the flag.
        access(0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 4'h9, "t4_mis", got);
        check("t4_word", got, 32'hDEADAAEF);
        access(0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 4'hA, "t4_misb", got);
        access(0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 4'hB, "t4_al", got);

        // Reset in the middle of a stalled store aborts it.
        old = {ref_mem[2][35], ref_mem[2][34], ref_mem[2][33], ref_mem[2][32]};
        size[2] = 2'b10; en[2] = 1'b1; rw[2] = 1'b1; wd[2] = 32'h12345678;
        alu[2] = 32'h20; ld[2] = 1'b1; rf[2] = 1'b1; rd[2] = 4'hC;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy_stall", 32'(stall[2]), 32'd1);
        clr[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero(2, "t5_clr");
        clr[2] = 1'b0;
        en[2]  = 1'b0;
        #1;
        check("t5_idle_stall", 32'(stall[2]), 32'd0);
        @(negedge clk);
        access(2, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 4'hD, "t5_ld", got);
        check("t5_old", got, old);

        // Address wrap and pass-through without a request.
        access(0, 2'b00, 1'b1, 32'h1FF, 32'h0000005A, 1'b0, 1'b0, 4'hE, "t6_st", got);
        access(0, 2'b00, 1'b0, 32'hFF, 32'h0, 1'b1, 1'b1, 4'hF, "t6_ld", got);
        check("t6_wrap", got, 32'h5A);
        idle(0, 32'hA5A5_1234, 4'h3, 1'b1, 1'b0, "t6_idle0");
        idle(1, 32'h0000_0ABC, 4'hC, 1'b0, 1'b1, "t6_idle1");

        // Randomised mix across all three instances.
        repeat (200) begin
            d = int'($urandom_range(2, 0));
            if ($urandom_range(3, 0) == 0) begin
                idle(d, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), "rnd_idle");
            end else begin
                access(d, 2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                       1'($urandom), 4'($urandom), "rnd", got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
